bank_array_xbar: RTL

// - Parametrised multi-port banked scratchpad: NP requesters share NB SRAM banks through a crossbar.
// - Each bank has a per-bank round-robin arbiter with a req/gnt handshake.
// - Sub-word write/read modes, alignment checking, and read data returned to the granted port.
// - Successor of the fixed 16-bank, 1-port-per-bank array. Any port can reach any bank; bank conflicts are arbitrated.

---
 rtl/bank_array_xbar.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/bank_array_xbar.sv
// bank_array_xbar: banked scratchpad shared by NP requester ports.
// Every port can reach every bank through a crossbar. Each bank has its own
// round-robin arbiter, so a port gets at most one grant per cycle, and ports
// that target different banks are served in parallel. Writes and reads can be
// sub-word, with a byte offset. A read returns its data one cycle after the
// grant, right-aligned and zero-extended.
module bank_array_xbar #(
  parameter int NP    = 4,
  parameter int NB    = 16,
  parameter int DW    = 256,
  parameter int ROW_W = 10,
  localparam int OFF_W  = $clog2(DW / 8),
  localparam int BK_W   = $clog2(NB),
  localparam int AW     = ROW_W + BK_W + OFF_W,
  localparam int MODMAX = OFF_W,
  localparam int NBYTES = DW / 8,
  localparam int PW     = (NP > 1) ? $clog2(NP) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NP-1:0]   req_i,
  input  logic [NP-1:0]   we_i,
  input  logic [NP*3-1:0] mod_i,
  input  logic [NP*AW-1:0] addr_i,
  input  logic [NP*DW-1:0] wdata_i,
  output logic [NP-1:0]   gnt_o,
  output logic [NP-1:0]   rvalid_o,
  output logic [NP*DW-1:0] rdata_o,
  output logic [NP-1:0]   err_o
);

  // Per-port decoded request fields
  logic [BK_W-1:0]  p_bank  [NP];
  logic [ROW_W-1:0] p_row   [NP];
  logic [OFF_W-1:0] p_off   [NP];
  logic [2:0]       p_mod   [NP];
  logic [DW-1:0]    p_wdata [NP];
  logic [NP-1:0]    p_legal;

  // Per-bank arbitration results and read-port outputs
  logic [NB-1:0]    bank_gnt;
  logic [NP-1:0]    bank_gnt_vec [NB];
  logic [DW-1:0]    bank_rdata   [NB];

  genvar gi;

  // ---------------------------------------------------------------------------
  // Address decode and legality check per port
  // ---------------------------------------------------------------------------
  generate
    for (gi = 0; gi < NP; gi++) begin : g_decode
      logic [OFF_W-1:0] align_mask;

      assign p_bank[gi]  = addr_i[gi*AW + OFF_W +: BK_W];
      assign p_row[gi]   = addr_i[gi*AW + AW - 1 -: ROW_W];
      assign p_off[gi]   = addr_i[gi*AW +: OFF_W];
      assign p_mod[gi]   = mod_i[gi*3 +: 3];
      assign p_wdata[gi] = wdata_i[gi*DW +: DW];

      // Low offset bits that must be zero for the access to be size-aligned
      always_comb begin
        align_mask = '0;
        for (int j = 0; j < OFF_W; j++) begin
          if (j < int'(p_mod[gi])) begin
            align_mask[j] = 1'b1;
          end
        end
      end

      assign p_legal[gi] = (int'(p_mod[gi]) <= MODMAX) &&
                           ((p_off[gi] & align_mask) == '0);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Per-bank arbiter, crossbar mux and storage
  // ---------------------------------------------------------------------------
  generate
    for (gi = 0; gi < NB; gi++) begin : g_bank
      logic [NP-1:0]    cand;
      logic [PW-1:0]    ptr_reg;
      logic [PW-1:0]    sel;
      logic             found;
      logic             b_we;
      logic             b_legal;
      logic [ROW_W-1:0] b_row;
      logic [OFF_W-1:0] b_off;
      logic [2:0]       b_mod;
      logic [DW-1:0]    b_wdata;
      logic [DW-1:0]    b_wd_shift;
      logic [NBYTES-1:0] b_be;
      logic             b_wr;
      logic             b_rd;
      logic [DW-1:0]    mem [2**ROW_W];
      logic [DW-1:0]    bank_rd_reg;

      // Ports currently requesting this bank
      always_comb begin
        cand = '0;
        for (int p = 0; p < NP; p++) begin
          cand[p] = req_i[p] && (p_bank[p] == BK_W'(gi));
        end
      end

      // Round-robin pick: first candidate at or after ptr, wrapping mod NP
      always_comb begin
        int idx;
        idx   = 0;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < NP; k++) begin
          idx = int'(ptr_reg) + k;
          if (idx >= NP) begin
            idx = idx - NP;
          end
          if (!found && cand[idx]) begin
            found = 1'b1;
            sel   = PW'(idx);
          end
        end
      end

      // Grants are suppressed while reset is held
      assign bank_gnt[gi]     = found & rst_n;
      assign bank_gnt_vec[gi] = bank_gnt[gi] ? (NP'(1) << sel) : '0;

      // Rotate priority past the winner; hold when the bank is idle
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ptr_reg <= '0;
        end else if (bank_gnt[gi]) begin
          ptr_reg <= (sel == PW'(NP - 1)) ? '0 : sel + PW'(1);
        end
      end

      // Crossbar: route the winning port's request fields to this bank
      assign b_we    = we_i[sel];
      assign b_legal = p_legal[sel];
      assign b_row   = p_row[sel];
      assign b_off   = p_off[sel];
      assign b_mod   = p_mod[sel];
      assign b_wdata = p_wdata[sel];

      // Illegal accesses are consumed by the grant but never touch memory
      assign b_wr = bank_gnt[gi] & b_legal & b_we;
      assign b_rd = bank_gnt[gi] & b_legal & ~b_we;

      // Byte lanes covered by the access: off .. off + 2**mod - 1
      always_comb begin
        b_be = '0;
        for (int i = 0; i < NBYTES; i++) begin
          if ((i >= int'(b_off)) && (i < int'(b_off) + (1 << int'(b_mod)))) begin
            b_be[i] = 1'b1;
          end
        end
      end

      // Right-aligned write data moved up to its byte offset
      assign b_wd_shift = b_wdata << {b_off, 3'b000};

      // Byte-enabled write and registered read; contents are never reset
      always_ff @(posedge clk) begin
        if (b_wr) begin
          for (int i = 0; i < NBYTES; i++) begin
            if (b_be[i]) begin
              mem[b_row][i*8 +: 8] <= b_wd_shift[i*8 +: 8];
            end
          end
        end
        if (b_rd) begin
          bank_rd_reg <= mem[b_row];
        end
      end

      assign bank_rdata[gi] = bank_rd_reg;
    end
  endgenerate

  // A port is granted when any bank picked it; each port targets one bank
  always_comb begin
    gnt_o = '0;
    for (int b = 0; b < NB; b++) begin
      gnt_o = gnt_o | bank_gnt_vec[b];
    end
  end

  // ---------------------------------------------------------------------------
  // Per-port response path: rvalid/err pulses and read-data extraction
  // ---------------------------------------------------------------------------
  generate
    for (gi = 0; gi < NP; gi++) begin : g_resp
      logic             rvalid_reg;
      logic             err_reg;
      logic [BK_W-1:0]  rd_bank_reg;
      logic [OFF_W-1:0] rd_off_reg;
      logic [2:0]       rd_mod_reg;
      logic [DW-1:0]    rdata_hold_reg;
      logic [DW-1:0]    rd_shift;
      logic [DW-1:0]    rd_mask;
      logic [DW-1:0]    rd_word;
      logic             rd_fire;

      assign rd_fire = gnt_o[gi] & p_legal[gi] & ~we_i[gi];

      // Remember where the granted read lives so the next cycle can slice it
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rvalid_reg     <= 1'b0;
          err_reg        <= 1'b0;
          rd_bank_reg    <= '0;
          rd_off_reg     <= '0;
          rd_mod_reg     <= '0;
          rdata_hold_reg <= '0;
        end else begin
          rvalid_reg <= rd_fire;
          err_reg    <= gnt_o[gi] & ~p_legal[gi];
          if (rd_fire) begin
            rd_bank_reg <= p_bank[gi];
            rd_off_reg  <= p_off[gi];
            rd_mod_reg  <= p_mod[gi];
          end
          if (rvalid_reg) begin
            rdata_hold_reg <= rd_word;
          end
        end
      end

      // Keep only the low 2**mod bytes of the offset-aligned row
      always_comb begin
        rd_mask = '0;
        for (int i = 0; i < NBYTES; i++) begin
          if (i < (1 << int'(rd_mod_reg))) begin
            rd_mask[i*8 +: 8] = 8'hFF;
          end
        end
      end

      assign rd_shift = bank_rdata[rd_bank_reg] >> {rd_off_reg, 3'b000};
      assign rd_word  = rd_shift & rd_mask;

      // Fresh data in the valid cycle, otherwise the last delivered word
      assign rdata_o[gi*DW +: DW] = rvalid_reg ? rd_word : rdata_hold_reg;
      assign rvalid_o[gi]         = rvalid_reg;
      assign err_o[gi]            = err_reg;
    end
  endgenerate

endmodule
